// File: rtl/sorting_pkg.sv
// Shared defaults, FSM encoding and index/count widths for the sorting unloader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sorting_pkg;

    localparam int SIZE_DEF  = 16;
    localparam int WIDTH_DEF = 32;
    localparam int IDX_W     = 4;   // source index width (covers SIZE_DEF entries)
    localparam int CNT_W     = 5;   // count width (covers 0..SIZE_DEF inclusive)

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE   = 1'b0;
    localparam state_t ST_STREAM = 1'b1;

endpackage

// File: rtl/sorting_snapshot.sv
// Capture bank for one parallel sorted vector with a single indexed read port.
// Latency: capture lands at the clock edge; read is combinational, with a bypass to in_data in the capture cycle.
// Backpressure: none; capture is fully controlled by the parent.
module sorting_snapshot
    import sorting_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [SIZE*WIDTH-1:0] in_data,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [WIDTH-1:0]      rd_data
);

    logic [SIZE*WIDTH-1:0] bank;

    // Snapshot the whole vector when the parent accepts a load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank <= '0;
        end else if (capture) begin
            bank <= in_data;
        end
    end

    // In the capture cycle the bank is not yet written, so the first beat reads straight from in_data.
    assign rd_data = capture ? in_data[int'(rd_idx)*WIDTH +: WIDTH]
                             : bank[int'(rd_idx)*WIDTH +: WIDTH];

endmodule

// File: rtl/sorting_unloader.sv
// Streams a captured sorted vector out one entry per beat; SORT_UNLOAD_DESC_EN streams largest first.
// Latency: first beat valid one cycle after load accept; one beat per cycle while out_ready is high.
// Backpressure: out_valid/out_ready; outputs are registered and held while out_ready is low; en low freezes everything.
module sorting_unloader
    import sorting_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    output logic                  load_ready,
    input  logic [CNT_W-1:0]      load_count,
    input  logic [SIZE*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [IDX_W-1:0]      out_index,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);

    state_t             state;
    logic [CNT_W-1:0]   cnt;        // clamped count of the active load
    logic [CNT_W-1:0]   beat;       // ordinal of the beat currently presented
    logic               accept;
    logic               xfer;
    logic [CNT_W-1:0]   cnt_clamp;
    logic [CNT_W-1:0]   cnt_sel;
    logic [CNT_W-1:0]   beat_sel;
    logic [IDX_W-1:0]   rd_idx;
    logic [WIDTH-1:0]   rd_data;
    logic               last_nxt;

    assign load_ready = (state == ST_IDLE);
    assign busy       = (state == ST_STREAM);
    assign accept     = en & load & load_ready;
    assign xfer       = en & out_valid & out_ready;

    assign cnt_clamp  = (load_count > SIZE_C) ? SIZE_C : load_count;

    // The beat being prepared: ordinal 0 of a fresh load, or the successor of the current beat.
    assign cnt_sel    = accept ? cnt_clamp : cnt;
    assign beat_sel   = accept ? '0 : beat + CNT_W'(1);
    assign last_nxt   = (beat_sel == cnt_sel - CNT_W'(1));

`ifdef SORT_UNLOAD_DESC_EN
    assign rd_idx = cnt_sel[IDX_W-1:0] - beat_sel[IDX_W-1:0] - IDX_W'(1);
`else
    assign rd_idx = beat_sel[IDX_W-1:0];
`endif

    sorting_snapshot #(
        .SIZE  (SIZE),
        .WIDTH (WIDTH)
    ) u_snapshot (
        .clk     (clk),
        .rst     (rst),
        .capture (accept),
        .in_data (in_data),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // FSM, beat counter and registered output beat; en low holds all state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            beat      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (cnt_clamp == '0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= ST_STREAM;
                            cnt       <= cnt_clamp;
                            beat      <= '0;
                            out_valid <= 1'b1;
                            out_data  <= rd_data;
                            out_index <= rd_idx;
                            out_last  <= last_nxt;
                        end
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        if (out_last) begin
                            state     <= ST_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            beat      <= beat_sel;
                            out_data  <= rd_data;
                            out_index <= rd_idx;
                            out_last  <= last_nxt;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
